// File: rtl/price_display.sv
// Price display: converts the selected 16-bit price to BCD by double dabble
// and drives a multiplexed, active-low 4-digit seven-segment display.
module price_display #(
  parameter int SCAN_DIV      = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] single,
  input  logic [15:0] sum,
  input  logic        sel,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        busy,
  output logic        ovf
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [15:0] src;
  logic [15:0] last_val;
  logic        last_sel;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic [19:0] adj;
  logic [3:0]  cnt;
  logic [15:0] dig;
  logic [SW-1:0] scnt;
  logic [1:0]  idx;
  logic [3:0]  cur;
  logic        blank;
  logic [7:0]  segv;
  logic        z1;
  logic        z2;
  logic        z3;

  assign src  = sel ? sum : single;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (src != last_val || sel != last_sel) nxt = LOAD;
      LOAD:  nxt = SHIFT;
      SHIFT: if (cnt == 4'd15) nxt = LATCH;
      LATCH: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Double-dabble correction applied before every shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_val <= '0;
      last_sel <= 1'b0;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      dig      <= '0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          bin      <= src;
          last_val <= src;
          last_sel <= sel;
          bcd      <= '0;
          cnt      <= '0;
        end
        SHIFT: begin
          bcd <= {adj[18:0], bin[15]};
          bin <= {bin[14:0], 1'b0};
          cnt <= cnt + 4'd1;
        end
        LATCH: begin
          ovf <= (bcd[19:16] != 4'd0);
          dig <= bcd[15:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt <= '0;
      idx  <= '0;
    end else if (scnt == SW'(SCAN_DIV - 1)) begin
      scnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      scnt <= scnt + 1'b1;
    end
  end

  assign z3 = (dig[15:12] == 4'd0);
  assign z2 = z3 && (dig[11:8] == 4'd0);
  assign z1 = z2 && (dig[7:4] == 4'd0);

  always_comb begin
    cur   = dig[3:0];
    blank = 1'b0;
    unique case (idx)
      2'd0: cur = dig[3:0];
      2'd1: begin cur = dig[7:4];   blank = z1; end
      2'd2: begin cur = dig[11:8];  blank = z2; end
      2'd3: begin cur = dig[15:12]; blank = z3; end
      default: ;
    endcase
    if (BLANK_LEADING == 0) blank = 1'b0;
  end

  always_comb begin
    segv = 8'hFF;
    if (ovf) begin
      segv = 8'hBF;
    end else if (!blank) begin
      unique case (cur)
        4'd0: segv = 8'hC0;
        4'd1: segv = 8'hF9;
        4'd2: segv = 8'hA4;
        4'd3: segv = 8'hB0;
        4'd4: segv = 8'h99;
        4'd5: segv = 8'h92;
        4'd6: segv = 8'h82;
        4'd7: segv = 8'hF8;
        4'd8: segv = 8'h80;
        4'd9: segv = 8'h90;
        default: segv = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'hF;
      seg <= 8'hFF;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= segv;
    end
  end

endmodule

// File: doc/price_display.md
PRICE_DISPLAY -- requirements
Module: price_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clock cycles each digit is held in the scan.
REQ-002 SHALL have parameter BLANK_LEADING, default 1; when 1, leading zeros are blanked.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port single  input  16  per-item price value from the calculate stage.
REQ-006 SHALL have port sum  input  16  running total from the calculate stage.
REQ-007 SHALL have port sel  input  1  value select: 0 = single, 1 = sum.
REQ-008 SHALL have port an  output  4  digit enables, active low, one-hot; bit 0 = ones digit.
REQ-009 SHALL have port seg  output  8  segments, active low, {dp,g,f,e,d,c,b,a}.
REQ-010 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-011 SHALL have port ovf  output  1  high when the last converted value exceeds 9999.

Function
REQ-012 SHALL select src = sel ? sum : single, combinationally.
REQ-013 SHALL implement FSM states IDLE, LOAD, SHIFT, LATCH.
REQ-014 IDLE SHALL go to LOAD on the edge where src != last_val or sel != last_sel; otherwise it SHALL stay in IDLE.
REQ-015 LOAD SHALL, in 1 cycle, capture src into the shift register, capture src/sel into last_val/last_sel, clear 20-bit BCD accumulator and bit counter.
REQ-016 SHIFT SHALL last exactly 16 cycles; each cycle: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left 1.
REQ-017 LATCH SHALL, in 1 cycle, write ovf = (ten-thousands nibble != 0) and the 4 low BCD nibbles to the digit registers, then return to IDLE.
REQ-018 Digit registers and ovf SHALL update on the 18th edge after the IDLE->LOAD edge.
REQ-019 busy SHALL be 1 exactly in LOAD, SHIFT, and LATCH.
REQ-020 Input changes while busy SHALL be ignored; IDLE SHALL re-compare against last_val/last_sel, so the final value is always converted.
REQ-021 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index 0..3 SHALL advance, with 3 wrapping to 0.
REQ-022 an SHALL be registered: index k drives an = ~(1<<k).
REQ-023 seg SHALL be registered with dp always 1 (off).
REQ-024 Digits 0-9 SHALL encode as C0,F9,A4,B0,99,92,82,F8,80,90.
REQ-025 Blank SHALL encode as FF; dash SHALL encode as BF.
REQ-026 When ovf=1, every digit SHALL show dash, overriding blanking.
REQ-027 When BLANK_LEADING=1, digit k (k>=1) SHALL be blank if it and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-028 The displayed digits SHALL change only at LATCH and SHALL never show partial conversion results.

Reset
REQ-029 While reset=1, outputs SHALL immediately be an=1111, seg=FF, busy=0, ovf=0.
REQ-030 While reset=1, the FSM SHALL be in IDLE; digit registers, last_val, scan counter, digit index, and last_sel SHALL all be 0.
REQ-031 Reset asserted mid-conversion SHALL abort it with no LATCH write.
REQ-032 After reset release, the first edge SHALL drive index 0, showing an=1110, seg=C0.
REQ-033 After reset release, value 0 with sel=0 SHALL NOT start a conversion.

Verification (SCAN_DIV=4, BLANK_LEADING=1)
REQ-034 sel=0, single=225 -> busy high for 18 cycles; then digits 3..0 = FF, A4, A4, 92, ovf=0.
REQ-035 sel=1, sum=3375 -> digits 3..0 = B0, B0, F8, 92.
REQ-036 sum=10000, sel=1 -> ovf=1; all four digits BF.
REQ-037 single changes 225->100 during SHIFT -> 225 is latched first; next IDLE edge starts a new conversion; 100 is shown as FF, F9, C0, C0 18 edges later.
REQ-038 reset pulsed at SHIFT cycle 8 -> an=1111, seg=FF, busy=0 asynchronously; after release, display shows FF, FF, FF, C0.
REQ-039 Idle scan -> an sequence 1110, 1101, 1011, 0111, repeating, with each value held exactly 4 cycles.
